// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed-length stream of unsigned products and
// returns the total over a valid/ready handshake, with a sticky overflow flag.
module product_accumulator #(
  parameter int PW   = 16,
  parameter int AW   = 32,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CNTW-1:0] len,
  input  logic [PW-1:0]   prod,
  input  logic            prod_valid,
  output logic            prod_ready,
  output logic [AW-1:0]   acc_out,
  output logic            acc_valid,
  input  logic            acc_ready,
  output logic            busy,
  output logic            ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            prod_ready_q, prod_ready_d;
  logic            acc_valid_q, acc_valid_d;
  logic            busy_q, busy_d;

  logic            transfer;
  logic [AW:0]     sum_ext;

  assign transfer = prod_valid & prod_ready_q;

  // One extra bit on the adder exposes the carry out of the accumulator MSB.
  assign sum_ext = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = ACCUM;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      ACCUM: begin
        if (transfer) begin
          acc_d = sum_ext[AW-1:0];
          ovf_d = ovf_q | sum_ext[AW];
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (acc_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so none of them
    // depends combinationally on acc_ready or prod_valid.
    prod_ready_d = (state_d == ACCUM);
    acc_valid_d  = (state_d == HOLD);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      prod_ready_q <= prod_ready_d;
      acc_valid_q  <= acc_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign acc_valid  = acc_valid_q;
  assign busy       = busy_q;
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: drives a 32-bit and an 18-bit accumulator with the same
// product streams and compares both against an arithmetic reference sum.
module tb_product_accumulator;

  localparam int PW   = 16;
  localparam int CNTW = 8;
  localparam int AW_A = 32;
  localparam int AW_B = 18;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [CNTW-1:0] len;
  logic [PW-1:0]   prod;
  logic            prod_valid;
  logic            acc_ready;

  logic            prod_ready_a, acc_valid_a, busy_a, ovf_a;
  logic [AW_A-1:0] acc_out_a;
  logic            prod_ready_b, acc_valid_b, busy_b, ovf_b;
  logic [AW_B-1:0] acc_out_b;

  int errors = 0;
  int checks = 0;
  int unsigned seq[$];

  product_accumulator #(.PW(PW), .AW(AW_A), .CNTW(CNTW)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready_a),
    .acc_out    (acc_out_a),
    .acc_valid  (acc_valid_a),
    .acc_ready  (acc_ready),
    .busy       (busy_a),
    .ovf        (ovf_a)
  );

  product_accumulator #(.PW(PW), .AW(AW_B), .CNTW(CNTW)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready_b),
    .acc_out    (acc_out_b),
    .acc_valid  (acc_valid_b),
    .acc_ready  (acc_ready),
    .busy       (busy_b),
    .ovf        (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic exp_ready,
                            input logic exp_valid, input logic exp_busy);
    checkOutput({tag, ":a_prod_ready"}, 64'(prod_ready_a), 64'(exp_ready));
    checkOutput({tag, ":a_acc_valid"},  64'(acc_valid_a),  64'(exp_valid));
    checkOutput({tag, ":a_busy"},       64'(busy_a),       64'(exp_busy));
    checkOutput({tag, ":b_prod_ready"}, 64'(prod_ready_b), 64'(exp_ready));
    checkOutput({tag, ":b_acc_valid"},  64'(acc_valid_b),  64'(exp_valid));
    checkOutput({tag, ":b_busy"},       64'(busy_b),       64'(exp_busy));
  endtask

  task automatic checkAllZero(input string tag);
    checkState(tag, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, ":a_acc_out"}, 64'(acc_out_a), 64'd0);
    checkOutput({tag, ":a_ovf"},     64'(ovf_a),     64'd0);
    checkOutput({tag, ":b_acc_out"}, 64'(acc_out_b), 64'd0);
    checkOutput({tag, ":b_ovf"},     64'(ovf_b),     64'd0);
  endtask

  // Reference: the result is the plain integer total of the queued products,
  // reduced modulo 2**AW, with overflow whenever the true total exceeds 2**AW-1.
  function automatic longint unsigned model_total();
    longint unsigned t;
    t = 0;
    foreach (seq[i]) t += longint'(seq[i]);
    return t;
  endfunction

  task automatic applyStimulus(input string tag, input int gap_min, input int gap_max,
                               input int hold_cycles);
    int n;
    longint unsigned total;
    logic [63:0] exp_sum_a, exp_sum_b;
    logic [63:0] exp_ovf_a, exp_ovf_b;
    int gap;

    n         = seq.size();
    total     = model_total();
    exp_sum_a = total % (64'd1 << AW_A);
    exp_sum_b = total % (64'd1 << AW_B);
    exp_ovf_a = (total >= (64'd1 << AW_A)) ? 64'd1 : 64'd0;
    exp_ovf_b = (total >= (64'd1 << AW_B)) ? 64'd1 : 64'd0;

    @(negedge clk);
    start     = 1'b1;
    len       = CNTW'(n);
    acc_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    len   = CNTW'($urandom);

    if (n == 0) begin
      checkState({tag, ":empty"}, 1'b0, 1'b1, 1'b1);
    end else begin
      checkState({tag, ":accum"}, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) begin
        gap = $urandom_range(gap_max, gap_min);
        repeat (gap) begin
          prod_valid = 1'b0;
          prod       = PW'($urandom);
          @(negedge clk);
          checkState({tag, ":gap"}, 1'b1, 1'b0, 1'b1);
        end
        prod_valid = 1'b1;
        prod       = PW'(seq[i]);
        @(negedge clk);
        prod_valid = 1'b0;
        prod       = PW'($urandom);
        if (i < n - 1) checkState({tag, ":mid"}, 1'b1, 1'b0, 1'b1);
      end
      checkState({tag, ":done"}, 1'b0, 1'b1, 1'b1);
    end

    checkOutput({tag, ":a_sum"}, 64'(acc_out_a), exp_sum_a);
    checkOutput({tag, ":a_ovf"}, 64'(ovf_a),     exp_ovf_a);
    checkOutput({tag, ":b_sum"}, 64'(acc_out_b), exp_sum_b);
    checkOutput({tag, ":b_ovf"}, 64'(ovf_b),     exp_ovf_b);

    repeat (hold_cycles) begin
      start      = 1'($urandom_range(1, 0));
      len        = CNTW'($urandom);
      prod_valid = 1'($urandom_range(1, 0));
      prod       = PW'($urandom);
      @(negedge clk);
      checkState({tag, ":hold"}, 1'b0, 1'b1, 1'b1);
      checkOutput({tag, ":hold_a_sum"}, 64'(acc_out_a), exp_sum_a);
      checkOutput({tag, ":hold_b_sum"}, 64'(acc_out_b), exp_sum_b);
    end
    prod_valid = 1'b0;

    acc_ready = 1'b1;
    start     = 1'b1;
    len       = CNTW'(3);
    @(negedge clk);
    acc_ready = 1'b0;
    start     = 1'b0;
    checkState({tag, ":idle"}, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, ":idle_a_ovf"}, 64'(ovf_a), exp_ovf_a);
    checkOutput({tag, ":idle_b_ovf"}, 64'(ovf_b), exp_ovf_b);
    @(negedge clk);
    checkState({tag, ":idle2"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    len        = '0;
    prod       = '0;
    prod_valid = 1'b0;
    acc_ready  = 1'b0;

    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAllZero("post_reset_idle");

    seq = '{3, 5, 7, 9};
    applyStimulus("t1_basic", 0, 0, 1);

    seq = '{100, 200, 300};
    applyStimulus("t2_gaps", 2, 2, 1);

    seq = '{65535, 65535, 65535, 65535, 65535};
    applyStimulus("t3_wrap", 0, 0, 10);

    seq = '{};
    applyStimulus("t4_empty", 0, 0, 2);

    seq = '{4, 6, 8};
    applyStimulus("t5_long_hold", 0, 1, 10);

    // Reset part-way through a four-term sequence.
    @(negedge clk);
    start = 1'b1;
    len   = CNTW'(4);
    @(negedge clk);
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = PW'(10);
    @(negedge clk);
    prod = PW'(20);
    @(negedge clk);
    prod_valid = 1'b0;
    checkOutput("t6_pre_reset_a_sum", 64'(acc_out_a), 64'd30);
    checkState("t6_pre_reset", 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("t6_async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    seq = '{1, 1};
    applyStimulus("t6_after_reset", 0, 0, 1);

    for (int r = 0; r < 8; r++) begin
      int n;
      n   = $urandom_range(20, 1);
      seq = '{};
      for (int k = 0; k < n; k++) seq.push_back($urandom_range(65535, 0));
      applyStimulus($sformatf("rand%0d", r), 0, 2, $urandom_range(3, 0));
    end

    seq = '{};
    for (int k = 0; k < 255; k++) seq.push_back($urandom_range(65535, 0));
    applyStimulus("max_len", 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
